// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad key filter: FSM state type and the
// default timing constants for a 3 MHz system clock.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } key_state_e;

    localparam int KP_DEBOUNCE_CYCLES     = 60000;    // 20 ms
    localparam int KP_REPEAT_DELAY_CYCLES = 1500000;  // 500 ms
    localparam int KP_REPEAT_RATE_CYCLES  = 300000;   // 100 ms

    function automatic int kp_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/keypad_timer.sv
// Saturating load/increment counter with a terminal-count look-ahead flag,
// shared by the debounce and auto-repeat timing paths.
module keypad_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic [WIDTH-1:0] term,
    output logic             hit
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_r;

    // Counter register: load has priority, increment stops at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // High when one more increment reaches the terminal count.
    assign hit = (count_r >= (term - CNT_ONE));

endmodule

// File: rtl/keypad_key_filter.sv
// Keypad key filter: debounces scanner reports into press/release events,
// latches the accepted key and generates optional auto-repeat strobes.
module keypad_key_filter
    import keypad_pkg::*;
#(
    parameter int NROWS               = 4,
    parameter int NCOLS               = 4,
    parameter int DEBOUNCE_CYCLES     = KP_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES = KP_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_RATE_CYCLES  = KP_REPEAT_RATE_CYCLES
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            key_pressed,
    input  logic [NROWS-1:0]                row_idx,
    input  logic [NCOLS-1:0]                col_idx,
    input  logic                            repeat_en,
    output logic                            key_valid,
    output logic                            key_held,
    output logic                            key_release,
    output logic [NROWS-1:0]                key_row,
    output logic [NCOLS-1:0]                key_col,
    output logic [$clog2(NROWS*NCOLS)-1:0]  key_code
);

    localparam int CW = $clog2(kp_max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES)) + 1;
    localparam int KW = $clog2(NROWS * NCOLS);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $fatal(1, "DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_RATE_CYCLES < 1) begin : g_bad_rate
        $fatal(1, "REPEAT_RATE_CYCLES must be at least 1");
    end
    if (REPEAT_DELAY_CYCLES < 1) begin : g_bad_delay
        $fatal(1, "REPEAT_DELAY_CYCLES must be at least 1");
    end

    key_state_e       state_r, state_s;
    logic [NROWS-1:0] cand_row_r, cand_row_s, row_s;
    logic [NCOLS-1:0] cand_col_r, cand_col_s, col_s;
    logic [KW-1:0]    cand_code_s, code_s;
    logic             rep_phase_r, rep_phase_s;
    logic             cand_s, match_s;
    logic             valid_s, held_s, release_s;
    logic             deb_load_s, deb_inc_s, deb_hit_s;
    logic [CW-1:0]    deb_load_val_s;
    logic             rep_load_s, rep_inc_s, rep_hit_s;
    logic [CW-1:0]    rep_term_s;
    int               row_bin_s, col_bin_s;

    assign cand_s  = key_pressed && $onehot(row_idx) && $onehot(col_idx);
    assign match_s = cand_s && (row_idx == cand_row_r) && (col_idx == cand_col_r);
    // After the first repeat the timer runs against the shorter rate interval.
    assign rep_term_s = rep_phase_r ? CW'(REPEAT_RATE_CYCLES) : CW'(REPEAT_DELAY_CYCLES);

    keypad_timer #(.WIDTH(CW)) u_deb_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (deb_load_s),
        .load_val (deb_load_val_s),
        .inc      (deb_inc_s),
        .term     (CW'(DEBOUNCE_CYCLES)),
        .hit      (deb_hit_s)
    );

    keypad_timer #(.WIDTH(CW)) u_rep_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (rep_load_s),
        .load_val (CNT_ZERO),
        .inc      (rep_inc_s),
        .term     (rep_term_s),
        .hit      (rep_hit_s)
    );

    // Binary index of the latched candidate key.
    always_comb begin
        row_bin_s = 0;
        col_bin_s = 0;
        for (int r = 0; r < NROWS; r++) row_bin_s = cand_row_r[r] ? r : row_bin_s;
        for (int c = 0; c < NCOLS; c++) col_bin_s = cand_col_r[c] ? c : col_bin_s;
        cand_code_s = KW'(row_bin_s * NCOLS + col_bin_s);
    end

    // Next-state, timer control and next output values.
    always_comb begin
        state_s        = state_r;
        cand_row_s     = cand_row_r;
        cand_col_s     = cand_col_r;
        deb_load_s     = 1'b0;
        deb_load_val_s = CNT_ZERO;
        deb_inc_s      = 1'b0;
        rep_load_s     = 1'b0;
        rep_inc_s      = 1'b0;
        rep_phase_s    = rep_phase_r;
        valid_s        = 1'b0;
        held_s         = key_held;
        release_s      = 1'b0;
        row_s          = key_row;
        col_s          = key_col;
        code_s         = key_code;
        case (state_r)
            ST_IDLE: begin
                if (cand_s) begin
                    cand_row_s     = row_idx;
                    cand_col_s     = col_idx;
                    deb_load_s     = 1'b1;
                    deb_load_val_s = CNT_ONE;
                    state_s        = ST_DEBOUNCE;
                end else begin
                    deb_load_s = 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (match_s && deb_hit_s) begin
                    state_s     = ST_HELD;
                    valid_s     = 1'b1;
                    held_s      = 1'b1;
                    row_s       = cand_row_r;
                    col_s       = cand_col_r;
                    code_s      = cand_code_s;
                    deb_load_s  = 1'b1;
                    rep_load_s  = 1'b1;
                    rep_phase_s = 1'b0;
                end else if (match_s) begin
                    deb_inc_s = 1'b1;
                end else if (cand_s) begin
                    cand_row_s     = row_idx;
                    cand_col_s     = col_idx;
                    deb_load_s     = 1'b1;
                    deb_load_val_s = CNT_ONE;
                end else begin
                    state_s    = ST_IDLE;
                    deb_load_s = 1'b1;
                end
            end
            ST_HELD: begin
                if (match_s) begin
                    deb_load_s = 1'b1;
                end else begin
                    state_s        = ST_RELEASE;
                    deb_load_s     = 1'b1;
                    deb_load_val_s = CNT_ONE;
                end
            end
            ST_RELEASE: begin
                if (match_s) begin
                    state_s    = ST_HELD;
                    deb_load_s = 1'b1;
                end else if (deb_hit_s) begin
                    state_s    = ST_IDLE;
                    held_s     = 1'b0;
                    release_s  = 1'b1;
                    deb_load_s = 1'b1;
                end else begin
                    deb_inc_s = 1'b1;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                deb_load_s = 1'b1;
            end
        endcase
        // Every matching sample of an accepted key advances the repeat timer,
        // including the one that ends a short dropout.
        if (match_s && ((state_r == ST_HELD) || (state_r == ST_RELEASE))) begin
            if (repeat_en) begin
                if (rep_hit_s) begin
                    valid_s     = 1'b1;
                    rep_load_s  = 1'b1;
                    rep_phase_s = 1'b1;
                end else begin
                    rep_inc_s = 1'b1;
                end
            end else begin
                rep_load_s  = 1'b1;
                rep_phase_s = 1'b0;
            end
        end else begin
            rep_inc_s = 1'b0;
        end
    end

    // FSM state, candidate latch and repeat phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cand_row_r  <= {NROWS{1'b0}};
            cand_col_r  <= {NCOLS{1'b0}};
            rep_phase_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cand_row_r  <= cand_row_s;
            cand_col_r  <= cand_col_s;
            rep_phase_r <= rep_phase_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
            key_release <= 1'b0;
            key_row     <= {NROWS{1'b0}};
            key_col     <= {NCOLS{1'b0}};
            key_code    <= {KW{1'b0}};
        end else begin
            key_valid   <= valid_s;
            key_held    <= held_s;
            key_release <= release_s;
            key_row     <= row_s;
            key_col     <= col_s;
            key_code    <= code_s;
        end
    end

endmodule

// File: tb/tb_keypad_key_filter.sv
// Randomized and directed bench for keypad_key_filter, checked every cycle
// against a run-length based behavioural model of the filter.
module tb_keypad_key_filter;

    localparam int DEB   = 8;
    localparam int DELAY = 20;
    localparam int RATE  = 5;

    logic       clk;
    logic       rst_n;
    logic       key_pressed;
    logic [3:0] row_idx;
    logic [3:0] col_idx;
    logic       repeat_en;
    logic       key_valid;
    logic       key_held;
    logic       key_release;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [3:0] key_code;

    keypad_key_filter #(
        .NROWS               (4),
        .NCOLS               (4),
        .DEBOUNCE_CYCLES     (DEB),
        .REPEAT_DELAY_CYCLES (DELAY),
        .REPEAT_RATE_CYCLES  (RATE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_pressed (key_pressed),
        .row_idx     (row_idx),
        .col_idx     (col_idx),
        .repeat_en   (repeat_en),
        .key_valid   (key_valid),
        .key_held    (key_held),
        .key_release (key_release),
        .key_row     (key_row),
        .key_col     (key_col),
        .key_code    (key_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fails = 0;
    int cyc     = 0;
    int nvalid  = 0;
    int nrel    = 0;
    int vq[$];

    // Behavioural model state
    logic       m_valid, m_held, m_release;
    logic [3:0] m_row, m_col, m_code;
    int         m_acc, run_key, run_len, off_len, hold_time;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_held = 1'b0; m_release = 1'b0;
        m_row = 4'd0; m_col = 4'd0; m_code = 4'd0;
        m_acc = -1; run_key = -1; run_len = 0; off_len = 0; hold_time = 0;
    endtask

    // One sampled cycle: track run lengths of identical samples.
    task automatic model_step();
        int s;
        s = -1;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (key_pressed && ($countones(row_idx) == 1) && ($countones(col_idx) == 1))
            s = $clog2(row_idx) * 4 + $clog2(col_idx);
        m_valid = 1'b0;
        m_release = 1'b0;
        if (!m_held) begin
            if (s < 0) begin
                run_key = -1; run_len = 0;
            end else if (s == run_key) begin
                run_len++;
            end else begin
                run_key = s; run_len = 1;
            end
            if (run_len == DEB) begin
                m_held = 1'b1; m_valid = 1'b1; m_acc = s;
                m_row = 4'(1 << (s / 4)); m_col = 4'(1 << (s % 4)); m_code = 4'(s);
                hold_time = 0; off_len = 0; run_key = -1; run_len = 0;
            end
        end else if (s == m_acc) begin
            off_len = 0;
            if (repeat_en) begin
                hold_time++;
                if (hold_time >= DELAY && ((hold_time - DELAY) % RATE) == 0) m_valid = 1'b1;
            end else begin
                hold_time = 0;
            end
        end else begin
            off_len++;
            if (off_len == DEB) begin
                m_held = 1'b0; m_release = 1'b1; off_len = 0; hold_time = 0;
            end
        end
    endtask

    task automatic compare_outputs();
        logic [14:0] act_v, exp_v;
        act_v = {key_valid, key_held, key_release, key_row, key_col, key_code};
        exp_v = {m_valid, m_held, m_release, m_row, m_col, m_code};
        check("cycle_outputs", 32'(act_v), 32'(exp_v));
        check("valid_release_excl", 32'(key_valid & key_release), 32'd0);
        if (key_valid === 1'b1) begin
            nvalid++;
            vq.push_back(cyc);
        end
        if (key_release === 1'b1) nrel++;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        compare_outputs();
        #1;
    endtask

    task automatic apply(input logic p, input logic [3:0] r, input logic [3:0] c, input int n);
        key_pressed = p;
        row_idx = r;
        col_idx = c;
        repeat (n) tick();
    endtask

    task automatic pulse_reset(input int n);
        rst_n = 1'b0;
        key_pressed = 1'b0; row_idx = 4'd0; col_idx = 4'd0;
        model_reset();
        #1;
        check("reset_outputs_zero", 32'({key_valid, key_held, key_release, key_row, key_col, key_code}), 32'd0);
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int v0, r0, base, cur, kind, len;
        int exp_off[4];
        logic [3:0] one, bad_pat[5];
        exp_off = '{20, 25, 30, 35};
        bad_pat = '{4'b0000, 4'b0011, 4'b0101, 4'b1111, 4'b1100};
        one = 4'b0001;
        repeat_en = 1'b0;
        pulse_reset(3);
        apply(1'b0, 4'd0, 4'd0, 2);

        // Basic press and release of key 0
        v0 = nvalid;
        apply(1'b1, 4'b0001, 4'b0001, 8);
        check("press_valid", 32'(key_valid), 32'd1);
        check("press_code", 32'(key_code), 32'd0);
        check("press_held", 32'(key_held), 32'd1);
        apply(1'b0, 4'd0, 4'd0, 1);
        check("valid_one_cycle", 32'(key_valid), 32'd0);
        apply(1'b0, 4'd0, 4'd0, 7);
        check("release_strobe", 32'(key_release), 32'd1);
        check("release_held", 32'(key_held), 32'd0);
        check("press_valid_count", 32'(nvalid - v0), 32'd1);
        apply(1'b0, 4'd0, 4'd0, 1);
        check("release_one_cycle", 32'(key_release), 32'd0);

        // Key change mid-debounce
        v0 = nvalid;
        apply(1'b1, 4'b0001, 4'b0010, 5);
        apply(1'b1, 4'b0010, 4'b0010, 8);
        check("change_valid", 32'(key_valid), 32'd1);
        check("change_code", 32'(key_code), 32'd5);
        check("change_row", 32'(key_row), 32'b0010);
        check("change_col", 32'(key_col), 32'b0010);
        check("change_valid_count", 32'(nvalid - v0), 32'd1);
        apply(1'b0, 4'd0, 4'd0, 10);

        // Invalid patterns never accepted
        v0 = nvalid;
        apply(1'b1, 4'b0011, 4'b0001, 50);
        apply(1'b1, 4'b0001, 4'b0000, 50);
        check("invalid_no_valid", 32'(nvalid - v0), 32'd0);
        check("invalid_not_held", 32'(key_held), 32'd0);
        check("code_kept_after_release", 32'(key_code), 32'd5);

        // Short dropout while held
        v0 = nvalid; r0 = nrel;
        apply(1'b1, 4'b0100, 4'b1000, 8);
        check("dropout_code", 32'(key_code), 32'd11);
        apply(1'b0, 4'd0, 4'd0, 3);
        apply(1'b1, 4'b0100, 4'b1000, 5);
        check("dropout_held", 32'(key_held), 32'd1);
        check("dropout_valid_count", 32'(nvalid - v0), 32'd1);
        check("dropout_no_release", 32'(nrel - r0), 32'd0);
        apply(1'b0, 4'd0, 4'd0, 10);
        check("dropout_final_release", 32'(nrel - r0), 32'd1);

        // Auto-repeat timing
        repeat_en = 1'b1;
        base = vq.size();
        apply(1'b1, 4'b1000, 4'b0001, 8);
        check("repeat_code", 32'(key_code), 32'd12);
        apply(1'b1, 4'b1000, 4'b0001, 39);
        check("repeat_count", 32'(vq.size() - base), 32'd5);
        if (vq.size() - base == 5) begin
            for (int i = 1; i < 5; i++)
                check("repeat_offset", 32'(vq[base + i] - vq[base]), 32'(exp_off[i - 1]));
        end
        apply(1'b0, 4'd0, 4'd0, 10);
        repeat_en = 1'b0;

        // Reset during debounce and during hold
        apply(1'b1, 4'b0001, 4'b0100, 4);
        v0 = nvalid; r0 = nrel;
        pulse_reset(2);
        apply(1'b0, 4'd0, 4'd0, 20);
        check("rst_deb_no_strobe", 32'((nvalid - v0) + (nrel - r0)), 32'd0);
        apply(1'b1, 4'b0010, 4'b0001, 8);
        check("rst_hold_code", 32'(key_code), 32'd4);
        apply(1'b1, 4'b0010, 4'b0001, 3);
        v0 = nvalid; r0 = nrel;
        pulse_reset(2);
        apply(1'b0, 4'd0, 4'd0, 20);
        check("rst_hold_no_strobe", 32'((nvalid - v0) + (nrel - r0)), 32'd0);
        check("rst_hold_code_zero", 32'(key_code), 32'd0);

        // Randomized traffic
        cur = 0;
        for (int seg = 0; seg < 320; seg++) begin
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) repeat_en = 1'($urandom_range(0, 1));
            if (seg % 97 == 50) begin
                pulse_reset($urandom_range(1, 3));
            end else if (kind < 5) begin
                if ($urandom_range(0, 3) == 0) cur = $urandom_range(0, 15);
                len = $urandom_range(1, 45);
                apply(1'b1, one << (cur / 4), one << (cur % 4), len);
            end else if (kind < 8) begin
                apply(1'b0, one << (cur / 4), one << (cur % 4), $urandom_range(1, 12));
            end else begin
                apply(1'b1, bad_pat[$urandom_range(0, 4)], one << $urandom_range(0, 3), $urandom_range(1, 6));
            end
        end
        apply(1'b0, 4'd0, 4'd0, 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
